// File: rtl/iter_shifter.sv
// -----------------------------------------------------------------------------
// iter_shifter
//   Multi-cycle shifter for the ALU datapath. Performs SLL, SRL, SRA or ROR on a
//   WIDTH-bit operand, moving at most STEP bit positions per clock. The ALU
//   control starts an operation with start and stalls on busy. done pulses in
//   the cycle res becomes valid.
//
//   Latency: done is visible 1 + ceil(shamt/STEP) rising edges after the edge
//   that accepts start (shamt == 0 -> 1 edge).
//
// Parameters
//   WIDTH  operand/result width (power of two, >= 8)
//   STEP   maximum bit positions shifted per clock (power of two, 1..WIDTH)
//   SW     shift-amount width, derived as $clog2(WIDTH)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request; sampled only while busy = 0
//   op     in   2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 ROR
//   a      in   operand
//   shamt  in   shift amount, 0..WIDTH-1
//   busy   out  high while a shift is in progress
//   done   out  high for the cycle in which res is newly valid
//   res    out  result; held until the next accepted operation completes
//   zero   out  (SHIFTER_FLAGS_EN) res == 0
//   cout   out  (SHIFTER_FLAGS_EN) last bit shifted out of the operand
//
// Configuration
//   Define SHIFTER_FLAGS_EN to add the zero/cout flag ports and their flops.
// -----------------------------------------------------------------------------
module iter_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4,
  localparam int unsigned SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic             zero,
  output logic             cout
`endif
);

  // Step amount needs one extra bit so that STEP == WIDTH is representable.
  localparam int unsigned KW = SW + 1;
  localparam logic [KW-1:0] STEP_K  = KW'(STEP);
  localparam logic [KW-1:0] WIDTH_K = KW'(WIDTH);
  localparam logic [KW-1:0] ONE_K   = KW'(1);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  state_e             state_q;
  state_e             state_nxt;

  logic [1:0]         op_q;
  logic [WIDTH-1:0]   work_q;
  logic [SW-1:0]      rem_q;

  logic               accept;
  logic               last_step;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   shifted;

  logic               busy_nxt;
  logic               done_nxt;
  logic               load_res;
  logic [WIDTH-1:0]   res_nxt;
  logic [1:0]         op_nxt;
  logic [WIDTH-1:0]   work_nxt;
  logic [SW-1:0]      rem_nxt;

  // A new request is taken whenever no shift is in flight (IDLE or DONE).
  assign accept = start && (state_q != ST_SHIFT);

  // Positions moved this cycle: min(rem, STEP).
  always_comb begin
    k = {1'b0, rem_q};
    if ({1'b0, rem_q} > STEP_K) begin
      k = STEP_K;
    end
  end

  // k == rem means the remaining distance is covered this cycle.
  assign last_step = (k == {1'b0, rem_q});

  // One partial shift of the working register. In SHIFT, k is 1..WIDTH-1,
  // so the rotate complement WIDTH-k never reaches WIDTH.
  always_comb begin
    shifted = work_q;
    unique case (op_e'(op_q))
      OP_SLL: shifted = work_q << k;
      OP_SRL: shifted = work_q >> k;
      OP_SRA: shifted = WIDTH'($unsigned($signed(work_q) >>> k));
      OP_ROR: shifted = (work_q >> k) | (work_q << (WIDTH_K - k));
      default: shifted = work_q;
    endcase
  end

`ifdef SHIFTER_FLAGS_EN
  // Bit leaving the register on this step; on the final step it is the last
  // bit shifted out of the whole operation.
  logic [WIDTH-1:0] left_probe;
  logic [WIDTH-1:0] right_probe;
  logic             step_out;
  logic             zero_nxt;
  logic             cout_nxt;

  always_comb begin
    left_probe  = work_q << (k - ONE_K);
    right_probe = work_q >> (k - ONE_K);
    step_out    = (op_e'(op_q) == OP_SLL) ? left_probe[WIDTH-1] : right_probe[0];
  end
`else
  // Without flags only the shifted value matters; ONE_K is kept referenced.
  logic unused_one_k;
  assign unused_one_k = ^ONE_K;
`endif

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_step) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt = (shamt == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath next-value logic.
  always_comb begin
    busy_nxt = (state_nxt == ST_SHIFT);
    done_nxt = (state_nxt == ST_DONE);
    load_res = 1'b0;
    res_nxt  = res;
    op_nxt   = op_q;
    work_nxt = work_q;
    rem_nxt  = rem_q;
`ifdef SHIFTER_FLAGS_EN
    cout_nxt = 1'b0;
`endif
    if (accept) begin
      op_nxt   = op;
      work_nxt = a;
      rem_nxt  = shamt;
      if (shamt == '0) begin
        load_res = 1'b1;
        res_nxt  = a;
      end
    end else if (state_q == ST_SHIFT) begin
      work_nxt = shifted;
      rem_nxt  = rem_q - SW'(k);
      if (last_step) begin
        load_res = 1'b1;
        res_nxt  = shifted;
`ifdef SHIFTER_FLAGS_EN
        cout_nxt = step_out;
`endif
      end
    end
`ifdef SHIFTER_FLAGS_EN
    zero_nxt = (res_nxt == '0);
`endif
  end

  // Captured operation and working state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 2'b00;
      work_q <= '0;
      rem_q  <= '0;
    end else begin
      op_q   <= op_nxt;
      work_q <= work_nxt;
      rem_q  <= rem_nxt;
    end
  end

  // Result changes only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
    end else if (load_res) begin
      res <= res_nxt;
    end
  end

`ifdef SHIFTER_FLAGS_EN
  // Flags are registered together with res.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      cout <= 1'b0;
    end else if (load_res) begin
      zero <= zero_nxt;
      cout <= cout_nxt;
    end
  end
`else
  // No flag flops in this build.
`endif

endmodule
